// File: rtl/log_converter_pipe.sv
// -----------------------------------------------------------------------------
// log_converter_pipe
//   Two-stage valid/ready pipeline that converts an unsigned operand into a
//   Mitchell-style binary logarithm: characteristic k (index of the leading
//   one) plus the bits below the leading one as an MSB-aligned fraction.
//     S1: leading-one detect  -> registers k, operand, zero flag
//     S2: normalise           -> registers out_char, out_frac, out_zero
//   Optional feature macro: LOG_FRAC_CORR_EN
//     When defined, S2 adds 2^(WIDTH-4) to the fraction (saturating) for
//     non-zero operands with k > 0, a simple bias correction for Mitchell's
//     approximation. Latency and handshake are unchanged.
//   WIDTH must be at least 4.
// -----------------------------------------------------------------------------
module log_converter_pipe #(
  parameter int WIDTH  = 8,
  parameter int CHAR_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic [WIDTH-1:0]  out_frac,
  output logic              out_zero
);

  // Stage 1 state
  logic              s1_valid_q, s1_valid_d;
  logic [CHAR_W-1:0] s1_char_q,  s1_char_d;
  logic [WIDTH-1:0]  s1_data_q,  s1_data_d;
  logic              s1_zero_q,  s1_zero_d;

  // Stage 2 state (drives the outputs directly)
  logic              out_valid_q, out_valid_d;
  logic [CHAR_W-1:0] out_char_q,  out_char_d;
  logic [WIDTH-1:0]  out_frac_q,  out_frac_d;
  logic              out_zero_q,  out_zero_d;

  // Handshake and datapath intermediates
  logic              s2_ready;
  logic              in_fire;
  logic              s1_move;
  logic [CHAR_W-1:0] lod_k;
  logic              lod_zero;
  logic [WIDTH-1:0]  aligned;
  logic [WIDTH-1:0]  frac_norm;

  // Stage readiness: a stage can take new data if empty or draining this cycle.
  // in_ready is derived only from state and out_ready, never from in_valid.
  assign s2_ready = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign in_fire  = in_valid && in_ready;
  assign s1_move  = s1_valid_q && s2_ready;

  // Leading-one detector: the last assignment in the upward scan wins,
  // so lod_k ends up as the index of the most significant set bit.
  // NOTE: every variable written in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    lod_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_data[i]) lod_k = CHAR_W'(i);
    end
  end

  assign lod_zero = (in_data == '0);

  // Normalise: shift the leading one up to the MSB, then drop it. For k = 0
  // the only set bit is the leading one, so the fraction comes out as zero.
  assign aligned   = s1_data_q << (CHAR_W'(WIDTH - 1) - s1_char_q);
  assign frac_norm = {aligned[WIDTH-2:0], 1'b0};

  // Stage 1 next state: load on input transfer, empty when handed to S2
  // without a replacement arriving in the same cycle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_char_d  = s1_char_q;
    s1_data_d  = s1_data_q;
    s1_zero_d  = s1_zero_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_char_d  = lod_k;
      s1_data_d  = in_data;
      s1_zero_d  = lod_zero;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: load from S1 when it moves, otherwise empty on
  // output transfer. Holding everything else keeps outputs stable under stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_frac_d  = out_frac_q;
    out_zero_d  = out_zero_q;
    if (s1_move) begin
      out_valid_d = 1'b1;
      out_char_d  = s1_char_q;
      out_zero_d  = s1_zero_q;
`ifdef LOG_FRAC_CORR_EN
      begin : g_corr
        logic [WIDTH:0] sum;
        sum = {1'b0, frac_norm} + ((WIDTH+1)'(1) << (WIDTH - 4));
        if (!s1_zero_q && (s1_char_q != '0)) begin
          out_frac_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end else begin
          out_frac_d = frac_norm;
        end
      end
`else
      out_frac_d  = frac_norm;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers with asynchronous active-low reset.
  // NOTE: the data registers are reset along with the valid flags because the
  // outputs must read zero while in reset; sequential state uses non-blocking
  // assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_char_q   <= '0;
      s1_data_q   <= '0;
      s1_zero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_frac_q  <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_char_q   <= s1_char_d;
      s1_data_q   <= s1_data_d;
      s1_zero_q   <= s1_zero_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_frac_q  <= out_frac_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_frac  = out_frac_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_log_converter_pipe.sv
// -----------------------------------------------------------------------------
// tb_log_converter_pipe
//   Directed bench for log_converter_pipe (WIDTH=8). Inputs change and outputs
//   are sampled on the falling clock edge; the DUT updates on the rising edge.
//   Expected fractions follow the LOG_FRAC_CORR_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_log_converter_pipe;

  localparam int WIDTH  = 8;
  localparam int CHAR_W = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CHAR_W-1:0] out_char;
  logic [WIDTH-1:0]  out_frac;
  logic              out_zero;

  int n_checks = 0;
  int n_fail   = 0;

  log_converter_pipe #(.WIDTH(WIDTH), .CHAR_W(CHAR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_frac  (out_frac),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected fractions with and without bias correction.
`ifdef LOG_FRAC_CORR_EN
  localparam int F_B2 = 'h74;
  localparam int F_17 = 'h80;
  localparam int F_5E = 'h88;
  localparam int F_FF = 'hFF;
  localparam int F_80 = 'h90;
`else
  localparam int F_B2 = 'h64;
  localparam int F_17 = 'h70;
  localparam int F_5E = 'h78;
  localparam int F_FF = 'hFE;
  localparam int F_80 = 'h80;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int ch, input int fr, input int z);
    check({tag, ".valid"}, 32'(out_valid), 1);
    check({tag, ".char"},  32'(out_char),  ch);
    check({tag, ".frac"},  32'(out_frac),  fr);
    check({tag, ".zero"},  32'(out_zero),  z);
  endtask

  // Back-to-back stimulus and expected results
  logic [7:0] b2b_data [4] = '{8'h00, 8'h01, 8'h17, 8'h5E};
  int         b2b_char [4] = '{0, 0, 4, 6};
  int         b2b_frac [4] = '{'h00, 'h00, F_17, F_5E};
  int         b2b_zero [4] = '{1, 0, 0, 0};

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // ---- Reset values (asynchronous) ----
    #2 rst_n = 1'b0;
    #1;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.out_char",  32'(out_char),  0);
    check("rst.out_frac",  32'(out_frac),  0);
    check("rst.out_zero",  32'(out_zero),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst.in_ready_after_release", 32'(in_ready), 1);

    // ---- Single operand 0xB2: result two cycles after acceptance ----
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hB2;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2.lat1_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    check_out("b2", 7, F_B2, 0);
    @(negedge clk);
    check("b2.drained", 32'(out_valid), 0);

    // ---- Saturation case 0xFF ----
    in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_out("ff", 7, F_FF, 0);

    // ---- Back-to-back 0x00, 0x01, 0x17, 0x5E at full throughput ----
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) check_out($sformatf("b2b%0d", i - 2), b2b_char[i-2], b2b_frac[i-2], b2b_zero[i-2]);
      if (i < 4) begin
        check($sformatf("b2b%0d.in_ready", i), 32'(in_ready), 1);
        in_valid = 1'b1; in_data = b2b_data[i];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b.drained", 32'(out_valid), 0);

    // ---- Backpressure: out_ready low for 5 cycles while streaming ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h03;
    @(negedge clk);
    check("bp.in_ready_one_held", 32'(in_ready), 1);
    in_data = 8'h0C;
    @(negedge clk);
    check("bp.in_ready_two_held", 32'(in_ready), 0);
    check_out("bp.hold0", 1, F_80, 0);
    in_data = 8'h18;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp.in_ready_stall%0d", i), 32'(in_ready), 0);
      check_out($sformatf("bp.hold%0d", i), 1, F_80, 0);
      if (i == 3) begin
        out_ready = 1'b1;
        #1 check("bp.in_ready_release", 32'(in_ready), 1);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_out("bp.r1", 3, F_80, 0);
    @(negedge clk);
    check_out("bp.r2", 4, F_80, 0);
    @(negedge clk);
    check("bp.drained", 32'(out_valid), 0);

    // ---- Reset with two operands in flight ----
    in_valid = 1'b1; in_data = 8'h40;
    @(negedge clk);
    in_data = 8'h20;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("mid.out_valid_before", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid.out_valid_async", 32'(out_valid), 0);
    check("mid.out_char_async",  32'(out_char),  0);
    check("mid.out_frac_async",  32'(out_frac),  0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1 check("mid.in_ready_after", 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mid.no_stale%0d", i), 32'(out_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/log_converter_pipe.md
LOG_CONVERTER_PIPE -- requirements
Module: log_converter_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be at least 4.
REQ-002 Parameter CHAR_W, default $clog2(WIDTH): characteristic width in bits.
REQ-003 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 in_valid  input  1: in_data is valid this cycle.
REQ-006 in_ready  output  1: block accepts in_data this cycle.
REQ-007 in_data  input  WIDTH: unsigned operand.
REQ-008 out_valid  output  1: result outputs are valid.
REQ-009 out_ready  input  1: downstream accepts the result this cycle.
REQ-010 out_char  output  CHAR_W: bit position k of the leading one of the operand.
REQ-011 out_frac  output  WIDTH: bits below the leading one, MSB-aligned, zero-filled at the LSB end.
REQ-012 out_zero  output  1: operand was zero.

Function
REQ-013 Transfer SHALL occur on a port only in a cycle where both valid and ready are high.
REQ-014 The datapath SHALL have two register stages: S1 (leading-one detect; registers k, operand, zero flag) and S2 (normalise; registers out_char, out_frac, out_zero).
REQ-015 s2_ready = !out_valid || out_ready; in_ready = !s1_valid || s2_ready; in_ready SHALL NOT depend combinationally on in_valid.
REQ-016 S1 SHALL load on input transfer; S2 SHALL load from S1 when s1_valid && s2_ready.
REQ-017 s1_valid SHALL clear when S1 moves to S2 with no new input transfer in the same cycle.
REQ-018 out_valid SHALL clear on output transfer when S1 is empty.
REQ-019 Latency SHALL be 2 cycles, input transfer to out_valid, with out_ready held high; throughput SHALL be 1 result per cycle.
REQ-020 While out_valid && !out_ready, out_char, out_frac and out_zero SHALL hold stable.
REQ-021 Simultaneous output transfer, S1-to-S2 move and input transfer in one cycle SHALL lose no data and duplicate no data.
REQ-022 k SHALL be the index of the most significant 1 in in_data.
REQ-023 The fraction SHALL equal (in_data << (WIDTH-k)) truncated to WIDTH bits; for k=0 it SHALL be 0.
REQ-024 For in_data = 0, the block SHALL set out_zero=1, out_char=0 and out_frac=0.
REQ-025 Results SHALL leave the block in acceptance order.

Reset
REQ-026 While rst_n=0, the block SHALL drive out_valid=0, s1_valid=0, out_char=0, out_frac=0 and out_zero=0, independent of clk.
REQ-027 in_ready SHALL be 1 in the first cycle after reset release.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operands, with no result emitted afterwards.

Configuration
REQ-029 Macro LOG_FRAC_CORR_EN controls Mitchell bias correction.
REQ-030 With LOG_FRAC_CORR_EN defined, S2 SHALL add 2^(WIDTH-4) to the fraction, saturating at all-ones, when out_zero=0 and k>0.
REQ-031 With LOG_FRAC_CORR_EN undefined, out_frac SHALL be the uncorrected fraction of REQ-023.
REQ-032 Latency and handshake SHALL be identical with and without LOG_FRAC_CORR_EN.

Verification (WIDTH=8)
REQ-033 in_data=0xB2, out_ready=1 -> after 2 cycles out_char=7, out_frac=0x64, out_zero=0; with LOG_FRAC_CORR_EN, out_frac=0x74.
REQ-034 Back-to-back 0x00, 0x01, 0x17, 0x5E -> consecutive cycles give (char,frac,zero) = (0,0x00,1), (0,0x00,0), (4,0x70,0), (6,0x78,0).
REQ-035 Input 0xFF with LOG_FRAC_CORR_EN -> out_char=7, out_frac=0xFF (saturated); without the macro, out_frac=0xFE.
REQ-036 out_ready=0 for 5 cycles while streaming 0x03, 0x0C, 0x18 -> in_ready drops after two results are held; outputs stay stable; after release, order is (1,0x80), (3,0x80), (4,0x80).
REQ-037 rst_n pulsed low for 1 cycle with two operands in flight -> out_valid=0 immediately; no stale result appears; in_ready=1 after release.
